// File: rtl/nacc_sequencer.sv
// ---------------------------------------------------------------------------
// nacc_sequencer
//
// Purpose: multi-cycle sequencer for the neuron-accumulate (NACC) operation.
// When decode issues, it latches the spike vector (SVR) and the neuron state
// (NSR). It then walks the active lanes of the weight vector register (WVR)
// through a read port with 1-cycle latency. Each weight whose spike bit is
// set is added to the accumulator with signed saturation. An optional
// threshold-and-fire step runs at the end, and the result is written back to
// the NSR.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start         issue pulse from decode (honoured only in IDLE)
//   start_vl      lane count code: 00=1, 01=2, 10=4, 11=4
//   start_fire    1 = threshold-and-fire after accumulation
//   flush         pipeline kill; aborts any operation in progress
//   svr_in        spike bits, latched at issue
//   nsr_in        current neuron state, latched at issue
//   threshold     signed firing threshold, sampled in WB
//   wvr_raddr     WVR lane read address
//   wvr_rdata     WVR read data, valid one cycle after wvr_raddr
//   stall         pipeline stall
//   busy          sequencer not in IDLE
//   nsr_we        NSR write enable (1-cycle pulse in WB)
//   nsr_wdata     value written to the NSR
//   spike_out     fire indication, valid with nsr_we
//   done          completion pulse, coincident with nsr_we
//
// Handshake: this block has no valid/ready pair. A start seen in IDLE
// without flush is accepted in that same cycle. stall covers the issuing
// cycle and every busy cycle. A start seen in any other state is dropped.
// ---------------------------------------------------------------------------
module nacc_sequencer #(
  parameter int DATA_W    = 32,
  parameter int WEIGHT_W  = 8,
  parameter int MAX_LANES = 4,
  parameter int LANE_AW   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           start_vl,
  input  logic                 start_fire,
  input  logic                 flush,
  input  logic [MAX_LANES-1:0] svr_in,
  input  logic [DATA_W-1:0]    nsr_in,
  input  logic [DATA_W-1:0]    threshold,
  output logic [LANE_AW-1:0]   wvr_raddr,
  input  logic [WEIGHT_W-1:0]  wvr_rdata,
  output logic                 stall,
  output logic                 busy,
  output logic                 nsr_we,
  output logic [DATA_W-1:0]    nsr_wdata,
  output logic                 spike_out,
  output logic                 done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_DRAIN = 2'b10,
    S_WB    = 2'b11
  } state_e;

  state_e                state_q,     state_d;
  logic [LANE_AW-1:0]    cnt_q,       cnt_d;
  logic [1:0]            vl_q,        vl_d;
  logic                  fire_mode_q, fire_mode_d;
  logic [MAX_LANES-1:0]  svr_q,       svr_d;
  logic [DATA_W-1:0]     acc_q,       acc_d;
  logic                  rd_valid_q,  rd_valid_d;
  logic [LANE_AW-1:0]    rd_tag_q,    rd_tag_d;
  logic [LANE_AW-1:0]    raddr_q,     raddr_d;

  logic [LANE_AW-1:0]    last_idx;
  logic [DATA_W:0]       addend;
  logic [DATA_W:0]       sum;
  logic [DATA_W-1:0]     sum_sat;
  logic                  wb_active;
  logic                  fire;

  // Index of the final lane for the latched length code (11 acts as 10).
  always_comb begin
    case (vl_q)
      2'b00:   last_idx = '0;
      2'b01:   last_idx = LANE_AW'(1);
      default: last_idx = LANE_AW'(MAX_LANES - 1);
    endcase
  end

  // Saturating accumulate, one bit wider than the state. Masked lanes add 0.
  always_comb begin
    addend = '0;
    if (svr_q[rd_tag_q]) begin
      addend = {{(DATA_W + 1 - WEIGHT_W){wvr_rdata[WEIGHT_W-1]}}, wvr_rdata};
    end
    sum = {acc_q[DATA_W-1], acc_q} + addend;
    if (sum[DATA_W] != sum[DATA_W-1]) begin
      // Overflow: the top bit of the wide sum gives the true sign.
      sum_sat = sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}}
                            : {1'b0, {(DATA_W-1){1'b1}}};
    end else begin
      sum_sat = sum[DATA_W-1:0];
    end
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    vl_d        = vl_q;
    fire_mode_d = fire_mode_q;
    svr_d       = svr_q;
    acc_d       = acc_q;
    rd_valid_d  = 1'b0;
    rd_tag_d    = rd_tag_q;
    raddr_d     = raddr_q;

    // Read data for the lane tagged last cycle arrives now.
    if (rd_valid_q) begin
      acc_d = sum_sat;
    end

    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          vl_d        = start_vl;
          fire_mode_d = start_fire;
          svr_d       = svr_in;
          acc_d       = nsr_in;
          cnt_d       = '0;
          raddr_d     = '0;
          state_d     = S_RUN;
        end
      end
      S_RUN: begin
        rd_valid_d = 1'b1;
        rd_tag_d   = cnt_q;
        cnt_d      = cnt_q + LANE_AW'(1);
        if (cnt_q == last_idx) begin
          // The address holds at the last lane once RUN ends.
          state_d = S_DRAIN;
        end else begin
          // The address register tracks cnt while in RUN.
          raddr_d = cnt_q + LANE_AW'(1);
        end
      end
      S_DRAIN: begin
        state_d = S_WB;
      end
      S_WB: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Flush wins over everything except reset. The read still in flight is dropped.
    if (flush && (state_q != S_IDLE)) begin
      state_d    = S_IDLE;
      rd_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      vl_q        <= '0;
      fire_mode_q <= 1'b0;
      svr_q       <= '0;
      acc_q       <= '0;
      rd_valid_q  <= 1'b0;
      rd_tag_q    <= '0;
      raddr_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      vl_q        <= vl_d;
      fire_mode_q <= fire_mode_d;
      svr_q       <= svr_d;
      acc_q       <= acc_d;
      rd_valid_q  <= rd_valid_d;
      rd_tag_q    <= rd_tag_d;
      raddr_q     <= raddr_d;
    end
  end

  // WB outputs are decoded from the registered state. The same-cycle flush
  // and the live threshold gate them here.
  assign wb_active = (state_q == S_WB) && !flush;
  assign fire      = fire_mode_q && ($signed(acc_q) >= $signed(threshold));

  assign wvr_raddr = raddr_q;
  assign busy      = (state_q != S_IDLE);
  assign stall     = busy | (start && (state_q == S_IDLE));
  assign nsr_we    = wb_active;
  assign done      = wb_active;
  assign spike_out = wb_active && fire;
  assign nsr_wdata = (wb_active && !fire) ? acc_q : '0;

endmodule

// File: tb/tb_nacc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_nacc_sequencer: directed bench for nacc_sequencer. A small WVR model
// returns weights one cycle after the address. Expected values are
// computed by hand from the operation definition.
// ---------------------------------------------------------------------------
module tb_nacc_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  start_vl;
  logic        start_fire;
  logic        flush;
  logic [3:0]  svr_in;
  logic [31:0] nsr_in;
  logic [31:0] threshold;
  logic [1:0]  wvr_raddr;
  logic [7:0]  wvr_rdata;
  logic        stall;
  logic        busy;
  logic        nsr_we;
  logic [31:0] nsr_wdata;
  logic        spike_out;
  logic        done;

  logic [7:0]  wvr_mem [4];

  int n_vec;
  int n_bad;

  nacc_sequencer #(
    .DATA_W(32), .WEIGHT_W(8), .MAX_LANES(4), .LANE_AW(2)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .start_vl(start_vl),
    .start_fire(start_fire), .flush(flush), .svr_in(svr_in),
    .nsr_in(nsr_in), .threshold(threshold), .wvr_raddr(wvr_raddr),
    .wvr_rdata(wvr_rdata), .stall(stall), .busy(busy), .nsr_we(nsr_we),
    .nsr_wdata(nsr_wdata), .spike_out(spike_out), .done(done)
  );

  // ---- clock / reset ----
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // WVR model: synchronous read, one cycle of latency.
  always @(posedge clk) wvr_rdata <= wvr_mem[wvr_raddr];

  // ---- checking ----
  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // ---- drivers ----
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic load_w(input logic [7:0] w0, input logic [7:0] w1,
                        input logic [7:0] w2, input logic [7:0] w3);
    wvr_mem[0] = w0; wvr_mem[1] = w1; wvr_mem[2] = w2; wvr_mem[3] = w3;
  endtask

  // Issue one op in the current cycle (t). Check every cycle through t+N+3.
  task automatic run_op(input string tag, input logic [1:0] vl,
                        input logic [3:0] svr, input logic [31:0] nsr,
                        input logic fire, input logic [31:0] thr,
                        input logic [31:0] exp_wdata, input logic exp_spike);
    int n;
    n = (vl == 2'b00) ? 1 : (vl == 2'b01) ? 2 : 4;
    start = 1'b1; start_vl = vl; svr_in = svr; nsr_in = nsr;
    start_fire = fire; threshold = thr;
    for (int k = 0; k <= n + 3; k++) begin
      @(negedge clk);
      chk({tag, "_stall"}, 32'(stall), 32'(k <= n + 2));
      chk({tag, "_busy"},  32'(busy),  32'((k >= 1) && (k <= n + 2)));
      chk({tag, "_we"},    32'(nsr_we), 32'(k == n + 2));
      chk({tag, "_done"},  32'(done),   32'(k == n + 2));
      if (k == n + 2) begin
        chk({tag, "_wdata"}, nsr_wdata, exp_wdata);
        chk({tag, "_spike"}, 32'(spike_out), 32'(exp_spike));
      end
      if ((k >= 1) && (k <= n)) chk({tag, "_raddr"}, 32'(wvr_raddr), 32'(k - 1));
      next_cycle();
      start = 1'b0;
    end
  endtask

  // Abort a 4-lane op at t+2, by flush (use_rst=0) or by reset (use_rst=1).
  task automatic abort_op(input string tag, input logic use_rst);
    load_w(8'd1, 8'd1, 8'd1, 8'd1);
    start = 1'b1; start_vl = 2'b10; svr_in = 4'b1111; nsr_in = 32'd7;
    start_fire = 1'b0; threshold = 32'd0;
    next_cycle();                      // t+1
    start = 1'b0;
    next_cycle();                      // t+2
    if (use_rst) rst = 1'b1; else flush = 1'b1;
    next_cycle();                      // t+3
    rst = 1'b0; flush = 1'b0;
    for (int k = 3; k <= 9; k++) begin
      @(negedge clk);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_we"},   32'(nsr_we), 32'd0);
      chk({tag, "_done"}, 32'(done),   32'd0);
      if (use_rst && (k == 3)) begin
        chk({tag, "_raddr"}, 32'(wvr_raddr), 32'd0);
        chk({tag, "_wdata"}, nsr_wdata, 32'd0);
      end
      next_cycle();
    end
  endtask

  // ---- stimulus ----
  initial begin
    n_vec = 0; n_bad = 0;
    rst = 1'b1; start = 1'b0; start_vl = 2'b00; start_fire = 1'b0;
    flush = 1'b0; svr_in = '0; nsr_in = '0; threshold = '0;
    load_w(8'd0, 8'd0, 8'd0, 8'd0);
    repeat (3) next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_we",    32'(nsr_we), 32'd0);
    chk("rst_done",  32'(done),   32'd0);
    chk("rst_spike", 32'(spike_out), 32'd0);
    chk("rst_raddr", 32'(wvr_raddr), 32'd0);
    chk("rst_wdata", nsr_wdata, 32'd0);
    next_cycle();

    // 10 + 5 - 3 = 12
    load_w(8'd5, 8'hFD, 8'd0, 8'd0);
    run_op("acc2", 2'b01, 4'b0011, 32'd10, 1'b0, 32'd0, 32'd12, 1'b0);

    // Only lanes 0 and 2 spike: 1 + 4 = 5
    load_w(8'd1, 8'd2, 8'd4, 8'd8);
    run_op("mask", 2'b10, 4'b0101, 32'd0, 1'b0, 32'd0, 32'd5, 1'b0);

    // 1 lane with lane 0 masked off: state passes through unchanged.
    run_op("one", 2'b00, 4'b1110, 32'hFFFF_FFF6, 1'b0, 32'd0, 32'hFFFF_FFF6, 1'b0);

    // 100 + 7 + 4 = 111 >= 110 fires; 111 < 112 does not.
    load_w(8'd7, 8'd4, 8'd0, 8'd0);
    run_op("fire", 2'b01, 4'b0011, 32'd100, 1'b1, 32'd110, 32'd0, 1'b1);
    run_op("nofire", 2'b01, 4'b0011, 32'd100, 1'b1, 32'd112, 32'd111, 1'b0);
    // Exactly equal to the threshold fires.
    run_op("fire_eq", 2'b01, 4'b0011, 32'd100, 1'b1, 32'd111, 32'd0, 1'b1);

    // Reserved code 11 acts as 4 lanes; saturation in both directions.
    load_w(8'd127, 8'd127, 8'd127, 8'd127);
    run_op("sat_pos", 2'b11, 4'b1111, 32'h7FFF_FFF0, 1'b0, 32'd0, 32'h7FFF_FFFF, 1'b0);
    load_w(8'h80, 8'h80, 8'h80, 8'h80);
    run_op("sat_neg", 2'b11, 4'b1111, 32'h8000_0010, 1'b0, 32'd0, 32'h8000_0000, 1'b0);

    abort_op("flush", 1'b0);
    abort_op("rstab", 1'b1);

    // Flush in WB suppresses the write and the spike.
    load_w(8'd3, 8'd0, 8'd0, 8'd0);
    start = 1'b1; start_vl = 2'b00; svr_in = 4'b0001; nsr_in = 32'd50;
    start_fire = 1'b1; threshold = 32'd0;
    next_cycle(); start = 1'b0;        // t+1 RUN
    next_cycle();                      // t+2 DRAIN
    next_cycle();                      // t+3 WB
    flush = 1'b1;
    @(negedge clk);
    chk("wbfl_we",    32'(nsr_we), 32'd0);
    chk("wbfl_done",  32'(done),   32'd0);
    chk("wbfl_spike", 32'(spike_out), 32'd0);
    next_cycle(); flush = 1'b0;
    @(negedge clk);
    chk("wbfl_busy", 32'(busy), 32'd0);
    next_cycle();

    // start and flush together in IDLE: start is dropped.
    start = 1'b1; flush = 1'b1;
    next_cycle(); start = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("stfl_busy", 32'(busy), 32'd0);
    next_cycle();

    // Issue rules: start at t+1 and at WB (t+4) is ignored; t+5 is accepted.
    load_w(8'd5, 8'hFD, 8'd0, 8'd0);
    start = 1'b1; start_vl = 2'b01; svr_in = 4'b0011; nsr_in = 32'd10;
    start_fire = 1'b0; threshold = 32'd0;
    next_cycle();                      // t+1
    nsr_in = 32'd999;
    next_cycle();                      // t+2
    start = 1'b0;
    next_cycle();                      // t+3
    next_cycle();                      // t+4 WB
    start = 1'b1;
    @(negedge clk);
    chk("iss_we4",    32'(nsr_we), 32'd1);
    chk("iss_wdata4", nsr_wdata, 32'd12);
    next_cycle();                      // t+5 IDLE
    nsr_in = 32'd50;
    @(negedge clk);
    chk("iss_busy5",  32'(busy),  32'd0);
    chk("iss_stall5", 32'(stall), 32'd1);
    next_cycle();                      // t+6
    start = 1'b0;
    for (int k = 6; k <= 9; k++) begin
      @(negedge clk);
      chk("iss_busy", 32'(busy), 32'd1);
      chk("iss_done", 32'(done), 32'(k == 9));
      if (k == 9) chk("iss_wdata9", nsr_wdata, 32'd52);
      next_cycle();
    end
    @(negedge clk);
    chk("iss_idle", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
